// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER fetch stage.
//   NOP_INSTR            - bubble instruction (addi x0,x0,0) placed in IF/ID
//   RESET_VECTOR_DEFAULT - default first fetch address after reset
//   fetch_state_t        - fetch occupancy: nothing pending, read in flight,
//                          or response parked in the hold buffer
//   fetch_state()        - decodes the two occupancy flags into a state
package otter_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HELD   = 2'd2
    } fetch_state_t;

    // infl and hold are never both set; hold takes precedence if they were.
    function automatic fetch_state_t fetch_state(input logic infl, input logic hold);
        if (hold)
            return HELD;
        else if (infl)
            return STREAM;
        else
            return EMPTY;
    endfunction

endpackage

// File: rtl/otter_fetch_stage_if.sv
// Instruction port (port 1) of the OTTER main memory.
//   MEM_ADDR1 - byte address of the instruction word to read
//   MEM_READ1 - read strobe
//   MEM_DOUT1 - read data, valid the cycle after a MEM_READ1=1 cycle
// master: the fetch stage; slave: the memory.
interface otter_fetch_stage_if;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;

    modport master (output MEM_ADDR1, output MEM_READ1, input  MEM_DOUT1);
    modport slave  (input  MEM_ADDR1, input  MEM_READ1, output MEM_DOUT1);
endinterface

// File: rtl/otter_fetch_stage_hold_buf.sv
// fetch_hold_buf: one-entry instruction/PC capture register.
// Parks the memory response that arrives while the pipe is stalled, because
// the synchronous memory will not present it again.
//   clk, rst       - clock, asynchronous active-high reset
//   capture        - load ir_in/pc_in and mark the entry valid
//   clear          - drop the entry (wins over capture)
//   ir_in, pc_in   - instruction and its address to park
//   valid, ir, pc  - parked entry
module fetch_hold_buf
    import otter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] ir,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ir    <= NOP_INSTR;
            pc    <= 32'h0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            ir    <= ir_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: instruction fetch for the pipelined OTTER RV32I core.
// Owns the PC, issues reads on memory port 1, absorbs the one-cycle read
// latency and fills the IF/ID register. Supports stall from the hazard unit
// and redirect (FLUSH) from execute.
//   CLK, RST       - clock, asynchronous active-high reset
//   STALL          - hold PC and IF/ID
//   FLUSH          - discard in-flight/held work, fetch REDIRECT_PC
//   REDIRECT_PC    - redirect target (bits [1:0] ignored)
//   mem            - memory port 1 (master side)
//   DEC_IR/PC/PC4  - IF/ID instruction, its address, address + 4
//   DEC_VALID      - IF/ID holds a real instruction
module otter_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       STALL,
    input  logic                       FLUSH,
    input  logic [31:0]                REDIRECT_PC,
    otter_fetch_stage_if.master        mem,
    output logic [31:0]                DEC_IR,
    output logic [31:0]                DEC_PC,
    output logic [31:0]                DEC_PC4,
    output logic                       DEC_VALID
);

    logic [31:0]  pc_q;
    logic         infl_q;
    logic [31:0]  infl_pc_q;
    logic         hold_q;
    logic [31:0]  hold_ir_q;
    logic [31:0]  hold_pc_q;
    logic         issue;
    logic [31:0]  fetch_addr;
    logic         hold_capture;
    logic         hold_clear;
    fetch_state_t state;

    assign state = fetch_state(infl_q, hold_q);

    // ---- Issue: address/strobe to memory port 1 ----
    // A redirect must issue even when stalled, otherwise the target would be
    // lost while the hazard unit holds the pipe.
    assign issue      = FLUSH | ~STALL;
    assign fetch_addr = FLUSH ? {REDIRECT_PC[31:2], 2'b00} : pc_q;

    // During reset the port reads the reset vector; the result is discarded.
    assign mem.MEM_READ1 = RST | issue;
    assign mem.MEM_ADDR1 = RST ? RESET_VECTOR : fetch_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q      <= RESET_VECTOR;
            infl_q    <= 1'b0;
            infl_pc_q <= RESET_VECTOR;
        end else if (issue) begin
            pc_q      <= fetch_addr + 32'd4;
            infl_q    <= 1'b1;
            infl_pc_q <= fetch_addr;
        end else begin
            infl_q    <= 1'b0;
        end
    end

    // ---- Response: park data that arrives during a stall ----
    assign hold_capture = STALL & ~FLUSH & (state == STREAM);
    assign hold_clear   = FLUSH | (~STALL & (state == HELD));

    fetch_hold_buf u_hold_buf (
        .clk     (CLK),
        .rst     (RST),
        .capture (hold_capture),
        .clear   (hold_clear),
        .ir_in   (mem.MEM_DOUT1),
        .pc_in   (infl_pc_q),
        .valid   (hold_q),
        .ir      (hold_ir_q),
        .pc      (hold_pc_q)
    );

    // ---- IF/ID register ----
    // Bubbles keep DEC_PC/DEC_PC4 so downstream sees a stable address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DEC_VALID <= 1'b0;
            DEC_IR    <= NOP_INSTR;
            DEC_PC    <= 32'h0;
            DEC_PC4   <= 32'h0;
        end else if (FLUSH) begin
            DEC_VALID <= 1'b0;
            DEC_IR    <= NOP_INSTR;
        end else if (!STALL) begin
            case (state)
                HELD: begin
                    DEC_VALID <= 1'b1;
                    DEC_IR    <= hold_ir_q;
                    DEC_PC    <= hold_pc_q;
                    DEC_PC4   <= hold_pc_q + 32'd4;
                end
                STREAM: begin
                    DEC_VALID <= 1'b1;
                    DEC_IR    <= mem.MEM_DOUT1;
                    DEC_PC    <= infl_pc_q;
                    DEC_PC4   <= infl_pc_q + 32'd4;
                end
                default: begin
                    DEC_VALID <= 1'b0;
                    DEC_IR    <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: two instances (reset vector 0 and 0xFFFF_FFF8)
// each with a synchronous-read memory model whose word at byte address a is
// 0x1000_0000 + a/4. Expected IF/ID contents are queued with the cycle they
// must appear in and compared when that cycle is reached.
module tb_otter_fetch_stage;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;

    always #5 CLK = ~CLK;

    otter_fetch_stage_if mif0 ();
    otter_fetch_stage_if mif1 ();

    logic [31:0] ir0, pc0, pc40, ir1, pc1, pc41;
    logic        v0, v1;

    otter_fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut0 (
        .CLK(CLK), .RST(RST), .STALL(stall), .FLUSH(flush), .REDIRECT_PC(redirect),
        .mem(mif0), .DEC_IR(ir0), .DEC_PC(pc0), .DEC_PC4(pc40), .DEC_VALID(v0)
    );

    otter_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) dut1 (
        .CLK(CLK), .RST(RST), .STALL(1'b0), .FLUSH(1'b0), .REDIRECT_PC(32'h0),
        .mem(mif1), .DEC_IR(ir1), .DEC_PC(pc1), .DEC_PC4(pc41), .DEC_VALID(v1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Memory models: data valid only the cycle after a read strobe.
    logic        rd0_q, rd1_q;
    logic [31:0] ad0_q, ad1_q;
    always @(posedge CLK) begin
        rd0_q <= mif0.MEM_READ1;
        ad0_q <= mif0.MEM_ADDR1;
        rd1_q <= mif1.MEM_READ1;
        ad1_q <= mif1.MEM_ADDR1;
    end
    assign mif0.MEM_DOUT1 = rd0_q ? mem_word(ad0_q) : 32'hxxxx_xxxx;
    assign mif1.MEM_DOUT1 = rd1_q ? mem_word(ad1_q) : 32'hxxxx_xxxx;

    typedef struct {
        int          cyc;
        int          dut;
        logic        v;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int d, input logic v,
                        input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.v   = v;
        e.ir  = v ? mem_word(pc) : NOP_INSTR;
        e.pc  = pc;
        e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic push_valid(input int c, input int d, input logic [31:0] pc);
        push(c, d, 1'b1, pc, pc + 32'd4);
    endtask

    task automatic check_due();
        exp_t        e;
        logic        v;
        logic [31:0] ir, pc, pc4;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                v = v0; ir = ir0; pc = pc0; pc4 = pc40;
            end else begin
                v = v1; ir = ir1; pc = pc1; pc4 = pc41;
            end
            chk($sformatf("c%0d_d%0d_valid", cyc, e.dut), {31'b0, v}, {31'b0, e.v});
            chk($sformatf("c%0d_d%0d_ir", cyc, e.dut), ir, e.ir);
            chk($sformatf("c%0d_d%0d_pc", cyc, e.dut), pc, e.pc);
            chk($sformatf("c%0d_d%0d_pc4", cyc, e.dut), pc4, e.pc4);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        check_due();
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_valid", {31'b0, v0}, 32'h0);
        chk("reset_ir", ir0, NOP_INSTR);
        chk("reset_pc", pc0, 32'h0);
        chk("reset_pc4", pc40, 32'h0);
        chk("reset_addr", mif0.MEM_ADDR1, 32'h0);
        chk("reset_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        chk("reset_addr_d1", mif1.MEM_ADDR1, 32'hFFFF_FFF8);

        // Streaming from both reset vectors, then a 3-cycle stall at DEC_PC=0x8
        push(0, 0, 1'b0, 32'h0, 32'h0);
        push(0, 1, 1'b0, 32'h0, 32'h0);
        push(1, 0, 1'b0, 32'h0, 32'h0);
        push(1, 1, 1'b0, 32'h0, 32'h0);
        push_valid(2, 0, 32'h0);
        push_valid(2, 1, 32'hFFFF_FFF8);
        push_valid(3, 0, 32'h4);
        push_valid(3, 1, 32'hFFFF_FFFC);
        push_valid(4, 0, 32'h8);
        push_valid(4, 1, 32'h0);
        push_valid(5, 0, 32'h8);
        push_valid(6, 0, 32'h8);
        push_valid(7, 0, 32'h8);
        push_valid(8, 0, 32'hC);
        push_valid(9, 0, 32'h10);
        push_valid(10, 0, 32'h14);

        RST = 1'b0;
        cyc = 0;
        check_due();
        chk("c0_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        chk("c0_addr", mif0.MEM_ADDR1, 32'h0);
        repeat (4) tick();

        stall = 1'b1;
        #1;
        chk("stall_read_c4", {31'b0, mif0.MEM_READ1}, 32'h0);
        tick();
        chk("stall_read_c5", {31'b0, mif0.MEM_READ1}, 32'h0);
        tick();
        chk("stall_read_c6", {31'b0, mif0.MEM_READ1}, 32'h0);
        tick();
        stall = 1'b0;
        #1;
        chk("release_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        chk("release_addr", mif0.MEM_ADDR1, 32'h10);
        repeat (3) tick();

        // Redirect to 0x200 in cycle 10
        flush = 1'b1;
        redirect = 32'h200;
        push(11, 0, 1'b0, 32'h14, 32'h18);
        push_valid(12, 0, 32'h200);
        push_valid(13, 0, 32'h204);
        #1;
        chk("flush_addr", mif0.MEM_ADDR1, 32'h200);
        chk("flush_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        tick();
        flush = 1'b0;
        tick();
        tick();

        // Enter HELD in cycle 13, then FLUSH+STALL with misaligned target
        stall = 1'b1;
        push_valid(14, 0, 32'h204);
        push(15, 0, 1'b0, 32'h204, 32'h208);
        push_valid(16, 0, 32'h100);
        push_valid(17, 0, 32'h104);
        tick();
        flush = 1'b1;
        redirect = 32'h103;
        #1;
        chk("flush_stall_addr", mif0.MEM_ADDR1, 32'h100);
        chk("flush_stall_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        tick();
        tick();

        // Reset asserted while HELD
        stall = 1'b1;
        push_valid(18, 0, 32'h104);
        tick();
        RST = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, v0}, 32'h0);
        chk("midrst_ir", ir0, NOP_INSTR);
        chk("midrst_pc", pc0, 32'h0);
        chk("midrst_pc4", pc40, 32'h0);
        chk("midrst_addr", mif0.MEM_ADDR1, 32'h0);
        chk("midrst_read", {31'b0, mif0.MEM_READ1}, 32'h1);
        stall = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        push(0, 0, 1'b0, 32'h0, 32'h0);
        push(1, 0, 1'b0, 32'h0, 32'h0);
        push_valid(2, 0, 32'h0);
        push_valid(2, 1, 32'hFFFF_FFF8);
        push_valid(3, 0, 32'h4);
        RST = 1'b0;
        cyc = 0;
        check_due();
        repeat (3) tick();

        chk("sb_drain", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/otter_fetch_stage.md
# otter_fetch_stage

Instruction-fetch stage of the pipelined OTTER RV32I core. Owns the program counter, drives port 1 (instruction port) of the byte-addressable main memory, absorbs its one-cycle synchronous read latency, and delivers an IF/ID pipeline register (instruction, PC, PC+4, valid) to the decode stage. Supports stall from the hazard unit and redirect/flush from execute (branch, jal, jalr, trap, mret).

## Interface
- RESET_VECTOR, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- STALL  in  1  hold IF/ID register and PC (hazard unit)
- FLUSH  in  1  redirect: discard in-flight/held instructions, fetch REDIRECT_PC
- REDIRECT_PC  in  32  redirect target, sampled when FLUSH=1
- MEM_ADDR1  out  32  instruction address to memory port 1
- MEM_READ1  out  1  read strobe to memory port 1
- MEM_DOUT1  in  32  instruction data, valid the cycle after a MEM_READ1=1 cycle
- DEC_IR  out  32  IF/ID instruction
- DEC_PC  out  32  IF/ID instruction address
- DEC_PC4  out  32  DEC_PC + 4
- DEC_VALID  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc_q (next sequential address), infl_q + infl_pc_q (read issued last cycle), hold_q + hold_ir_q + hold_pc_q (one-entry hold buffer), IF/ID outputs.
- States (encoded by infl_q/hold_q): EMPTY (neither), STREAM (infl_q=1), HELD (hold_q=1). infl_q and hold_q never both 1.
- Issue rule: MEM_READ1 = FLUSH | ~STALL. MEM_ADDR1 = FLUSH ? {REDIRECT_PC[31:2],2'b00} : pc_q (combinational).
- On issue: infl_q<=1, infl_pc_q<=MEM_ADDR1, pc_q<=MEM_ADDR1+4 (32-bit, wraps 0xFFFF_FFFC -> 0). No issue: infl_q<=0, pc_q held.
- FLUSH=1 (priority over STALL): IF/ID <= bubble (DEC_VALID=0, DEC_IR=NOP_INSTR, DEC_PC/DEC_PC4 held); hold_q<=0; in-flight response discarded.
- STALL=1, FLUSH=0: IF/ID held. STREAM -> HELD: capture MEM_DOUT1/infl_pc_q into hold buffer. HELD stays HELD. EMPTY stays EMPTY.
- STALL=0, FLUSH=0: IF/ID loads hold buffer if HELD (hold_q<=0), else MEM_DOUT1/infl_pc_q if STREAM, else bubble. DEC_PC4 = loaded PC + 4.
- REDIRECT_PC[1:0] ignored (no compressed ISA).

## Timing
- Reset values: pc_q=RESET_VECTOR, infl_q=0, hold_q=0, DEC_VALID=0, DEC_IR=NOP_INSTR, DEC_PC=0, DEC_PC4=0. While RST=1, MEM_ADDR1=RESET_VECTOR, MEM_READ1=1 (memory read harmless).
- First cycle after RST release = cycle 0: issue RESET_VECTOR; cycle 1 response + issue +4; DEC_VALID=1 with DEC_PC=RESET_VECTOR from cycle 2.
- Steady state: one instruction per cycle, fetch-to-IF/ID latency 2 edges.
- Redirect: FLUSH in cycle n -> bubble in IF/ID during n+1, target instruction in IF/ID during n+2 (1-cycle penalty).
- Stall release: no bubble; held instruction enters IF/ID on release edge, next sequential one edge later.
- RST mid-operation: all state returns to reset values immediately; pending fetches lost.

## Structure
- Shared package otter_pkg: NOP_INSTR constant, RESET_VECTOR default, fetch-state enum {EMPTY, STREAM, HELD} if encoded explicitly.
- One natural sub-module: fetch_hold_buf (one-entry ir/pc capture register with valid, async reset). Everything else in otter_fetch_stage.
- Memory behavioural model for bench: synchronous read, DOUT1 valid next cycle, undefined (X) when prior cycle MEM_READ1=0.

## Test plan
- Reset, memory word[i]=32'h1000_0000+i, no stall -> DEC_PC 0,4,8,... from cycle 2, DEC_IR matches, DEC_PC4=DEC_PC+4, DEC_VALID=1 continuously.
- STALL high 3 cycles while DEC_PC=0x8 -> DEC_PC stays 0x8, MEM_READ1=0 during stall, after release DEC_PC 0xC,0x10 on consecutive cycles, no duplicate/skipped PC.
- FLUSH one cycle with REDIRECT_PC=0x200 -> next cycle DEC_VALID=0, DEC_IR=0x0000_0013; following cycle DEC_PC=0x200, then 0x204.
- FLUSH and STALL together while HELD, REDIRECT_PC=0x103 -> hold discarded, bubble, then DEC_PC=0x100.
- RESET_VECTOR=0xFFFF_FFF8 -> DEC_PC 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; DEC_PC4 of 0xFFFF_FFFC is 0x0.
- RST asserted mid-stall (HELD) -> DEC_VALID=0, DEC_IR=NOP immediately; after release fetch restarts at RESET_VECTOR with 2-cycle latency.
